// File: rtl/ct_ifu_bht_pkg.sv
// Shared types and default sizing for the BHT selector array controller.
package ct_ifu_bht_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } bht_state_e;

    localparam int BHT_DEPTH = 128;
    localparam int BHT_WIDTH = 16;

endpackage

// File: rtl/ct_ifu_bht_sel_array_ctrl_if.sv
// Predict/update-side bus of the selector array: invalidate, read and update channels.
interface ct_ifu_bht_sel_array_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 7
);
    logic             inv_req;
    logic             busy;
    logic             rd_vld;
    logic [IDX_W-1:0] rd_index;
    logic             rd_ready;
    logic             rd_data_vld;
    logic [WIDTH-1:0] rd_data;
    logic             wr_vld;
    logic [IDX_W-1:0] wr_index;
    logic [WIDTH-1:0] wr_din;
    logic [WIDTH-1:0] wr_bmask;
    logic             wr_ready;

    modport master (
        output inv_req, rd_vld, rd_index, wr_vld, wr_index, wr_din, wr_bmask,
        input  busy, rd_ready, rd_data_vld, rd_data, wr_ready
    );

    modport slave (
        input  inv_req, rd_vld, rd_index, wr_vld, wr_index, wr_din, wr_bmask,
        output busy, rd_ready, rd_data_vld, rd_data, wr_ready
    );
endinterface

// File: rtl/ct_spsram_param.sv
// Single-port SRAM model: active-low CEN/GWEN/bit-WEN, one-cycle read latency.
module ct_spsram_param #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              gwen,
    input  logic [WIDTH-1:0]  wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  q
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array access; q holds the last read until the next read.
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                mem_r[addr] <= (mem_r[addr] & wen) | (din & ~wen);
            end else begin
                q <= mem_r[addr];
            end
        end
    end
endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate; enable is captured while the clock is low.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic clk_en_bf_latch_s;
    logic clk_en_s;

    assign clk_en_bf_latch_s = (global_en & (module_en | local_en)) | external_en;

    // Transparent-low enable latch keeps the gated clock glitch free.
    always_latch begin
        if (!clk_in) begin
            clk_en_s = clk_en_bf_latch_s | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_s;
endmodule

// File: rtl/ct_ifu_bht_sel_array_ctrl.sv
// BHT selector array controller: init sweep, one-entry write buffer with read bypass.
module ct_ifu_bht_sel_array_ctrl
    import ct_ifu_bht_pkg::*;
#(
    parameter int               DEPTH    = BHT_DEPTH,
    parameter int               WIDTH    = BHT_WIDTH,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    input  logic                          cp0_yy_clk_en,
    input  logic                          cp0_ifu_icg_en,
    input  logic                          pad_yy_icg_scan_en,
    ct_ifu_bht_sel_array_ctrl_if.slave    bus
);
    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    bht_state_e       state_r;
    logic [IDX_W-1:0] cnt_r;
    logic             buf_vld_r;
    logic [IDX_W-1:0] buf_index_r;
    logic [WIDTH-1:0] buf_din_r;
    logic [WIDTH-1:0] buf_bmask_r;
    logic             rd_data_vld_r;
    logic [WIDTH-1:0] byp_din_r;
    logic [WIDTH-1:0] byp_bmask_r;

    logic             busy_s, rd_acc_s, wr_acc_s, drain_s, byp_hit_s;
    logic             sram_lcl_en_s, sram_clk_s;
    logic             sram_cen_s, sram_gwen_s;
    logic [WIDTH-1:0] sram_wen_s, sram_din_s, sram_q_s;
    logic [IDX_W-1:0] sram_addr_s;

    assign busy_s    = (state_r == ST_INIT);
    assign rd_acc_s  = bus.rd_vld & ~busy_s;
    assign wr_acc_s  = bus.wr_vld & ~busy_s & ~buf_vld_r;
    // Buffer drains only in a cycle the port is not claimed by the sweep or a read.
    assign drain_s   = buf_vld_r & ~busy_s & ~rd_acc_s & ~bus.inv_req;
    assign byp_hit_s = buf_vld_r & (buf_index_r == bus.rd_index);
    assign sram_lcl_en_s = busy_s | rd_acc_s | drain_s | bus.inv_req;

    // SRAM port arbitration: sweep, then read, then buffer drain.
    always_comb begin
        sram_cen_s  = 1'b1;
        sram_gwen_s = 1'b1;
        sram_wen_s  = {WIDTH{1'b1}};
        sram_addr_s = cnt_r;
        sram_din_s  = INIT_VAL;
        if (busy_s) begin
            sram_cen_s  = 1'b0;
            sram_gwen_s = 1'b0;
            sram_wen_s  = {WIDTH{1'b0}};
        end else if (rd_acc_s && !bus.inv_req) begin
            sram_cen_s  = 1'b0;
            sram_addr_s = bus.rd_index;
        end else if (drain_s) begin
            sram_cen_s  = 1'b0;
            sram_gwen_s = 1'b0;
            sram_wen_s  = ~buf_bmask_r;
            sram_addr_s = buf_index_r;
            sram_din_s  = buf_din_r;
        end else begin
            sram_cen_s  = 1'b1;
        end
    end

    // Sweep FSM; inv_req restarts it from entry 0 in any state.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_r <= ST_INIT;
            cnt_r   <= {IDX_W{1'b0}};
        end else if (bus.inv_req) begin
            state_r <= ST_INIT;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {IDX_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + ONE_IDX;
                    end
                end
                ST_IDLE: state_r <= ST_IDLE;
                default: begin
                    state_r <= ST_INIT;
                    cnt_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Write buffer and read-return tracking with captured bypass data.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            buf_vld_r     <= 1'b0;
            buf_index_r   <= {IDX_W{1'b0}};
            buf_din_r     <= {WIDTH{1'b0}};
            buf_bmask_r   <= {WIDTH{1'b0}};
            rd_data_vld_r <= 1'b0;
            byp_din_r     <= {WIDTH{1'b0}};
            byp_bmask_r   <= {WIDTH{1'b0}};
        end else if (bus.inv_req) begin
            buf_vld_r     <= 1'b0;
            rd_data_vld_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                buf_vld_r   <= 1'b1;
                buf_index_r <= bus.wr_index;
                buf_din_r   <= bus.wr_din;
                buf_bmask_r <= bus.wr_bmask;
            end else if (drain_s) begin
                buf_vld_r   <= 1'b0;
            end
            rd_data_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                byp_din_r   <= buf_din_r;
                byp_bmask_r <= byp_hit_s ? buf_bmask_r : {WIDTH{1'b0}};
            end
        end
    end

    gated_clk_cell u_sram_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (sram_lcl_en_s),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (sram_clk_s)
    );

    ct_spsram_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_sram (
        .clk  (sram_clk_s),
        .cen  (sram_cen_s),
        .gwen (sram_gwen_s),
        .wen  (sram_wen_s),
        .addr (sram_addr_s),
        .din  (sram_din_s),
        .q    (sram_q_s)
    );

    assign bus.busy        = busy_s;
    assign bus.rd_ready    = ~busy_s;
    assign bus.wr_ready    = ~busy_s & ~buf_vld_r;
    assign bus.rd_data_vld = rd_data_vld_r;
    assign bus.rd_data     = rd_data_vld_r ?
                             ((sram_q_s & ~byp_bmask_r) | (byp_din_r & byp_bmask_r)) :
                             {WIDTH{1'b0}};
endmodule

// File: tb/tb_ct_ifu_bht_sel_array_ctrl.sv
// Directed bench for the BHT selector array controller (INIT_VAL overridden to 16'h3C3C).
module tb_ct_ifu_bht_sel_array_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic icg_en = 1'b0;
    logic scan_en = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ct_ifu_bht_sel_array_ctrl_if #(.WIDTH(16), .IDX_W(7)) bus ();

    ct_ifu_bht_sel_array_ctrl #(.DEPTH(128), .WIDTH(16), .INIT_VAL(16'h3C3C)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .cp0_yy_clk_en      (clk_en),
        .cp0_ifu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .bus                (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            n++;
            step();
        end
        chk(tag, n, 32'd128);
    endtask

    task automatic read1(input logic [6:0] idx, input logic [15:0] exp, input string tag);
        bus.rd_vld = 1'b1;
        bus.rd_index = idx;
        step();
        bus.rd_vld = 1'b0;
        chk({tag, "_vld"}, {31'd0, bus.rd_data_vld}, 32'd1);
        chk(tag, {16'd0, bus.rd_data}, {16'd0, exp});
    endtask

    initial begin
        bus.inv_req = 1'b0;
        bus.rd_vld = 1'b0;
        bus.rd_index = 7'd0;
        bus.wr_vld = 1'b0;
        bus.wr_index = 7'd0;
        bus.wr_din = 16'h0000;
        bus.wr_bmask = 16'h0000;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        chk("rst_rd_vld", {31'd0, bus.rd_data_vld}, 32'd0);
        chk("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        count_busy("sweep_len");
        chk("idle_wr_ready", {31'd0, bus.wr_ready}, 32'd1);

        // Every entry carries INIT_VAL after the sweep; back-to-back reads.
        bus.rd_vld = 1'b1;
        for (int i = 0; i < 128; i++) begin
            bus.rd_index = 7'(i);
            step();
            chk("sweep_rd", {15'd0, bus.rd_data_vld, bus.rd_data}, {15'd0, 1'b1, 16'h3C3C});
        end
        bus.rd_vld = 1'b0;
        step();
        chk("rd_vld_pulse", {31'd0, bus.rd_data_vld}, 32'd0);
        chk("rd_data_zero", {16'd0, bus.rd_data}, 32'd0);

        // Masked write to 5, then bypass read while buffered.
        bus.wr_vld = 1'b1; bus.wr_index = 7'd5; bus.wr_din = 16'hA5A5; bus.wr_bmask = 16'h00FF;
        step();
        bus.wr_vld = 1'b0;
        chk("wr5_buffered", {31'd0, bus.wr_ready}, 32'd0);
        read1(7'd5, 16'h3CA5, "byp5");
        chk("wr5_stalled", {31'd0, bus.wr_ready}, 32'd0);
        step();
        chk("wr5_drained", {31'd0, bus.wr_ready}, 32'd1);
        read1(7'd5, 16'h3CA5, "sram5");

        // Reads to other indices hold off the drain for 10 cycles.
        bus.wr_vld = 1'b1; bus.wr_index = 7'd20; bus.wr_din = 16'h1234; bus.wr_bmask = 16'hFFFF;
        step();
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.rd_index = 7'(30 + i);
            step();
            chk("stall_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
            chk("stall_rd", {16'd0, bus.rd_data}, 32'h3C3C);
        end
        bus.rd_vld = 1'b0;
        step();
        chk("stall_drained", {31'd0, bus.wr_ready}, 32'd1);
        read1(7'd20, 16'h1234, "sram20");

        // Same-cycle read and write of 9: read sees old value, next read the new.
        bus.wr_vld = 1'b1; bus.wr_index = 7'd9; bus.wr_din = 16'hFFFF; bus.wr_bmask = 16'hFFFF;
        bus.rd_vld = 1'b1; bus.rd_index = 7'd9;
        step();
        bus.wr_vld = 1'b0;
        chk("same9_old", {16'd0, bus.rd_data}, 32'h3C3C);
        read1(7'd9, 16'hFFFF, "same9_new");
        step();
        read1(7'd9, 16'hFFFF, "sram9");
        read1(7'd127, 16'h3C3C, "last_idx");

        // inv_req with a read in flight and a write buffered, then again at count 60.
        bus.wr_vld = 1'b1; bus.wr_index = 7'd7; bus.wr_din = 16'h0F0F; bus.wr_bmask = 16'hFFFF;
        step();
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b1; bus.rd_index = 7'd7; bus.inv_req = 1'b1;
        step();
        bus.rd_vld = 1'b0; bus.inv_req = 1'b0;
        chk("inv_rd_suppr", {31'd0, bus.rd_data_vld}, 32'd0);
        chk("inv_busy", {31'd0, bus.busy}, 32'd1);
        chk("inv_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
        repeat (60) step();
        chk("inv_mid_busy", {31'd0, bus.busy}, 32'd1);
        bus.inv_req = 1'b1;
        step();
        bus.inv_req = 1'b0;
        count_busy("inv_restart_len");
        chk("inv_buf_dropped", {31'd0, bus.wr_ready}, 32'd1);
        step();
        chk("inv_no_drain", {31'd0, bus.wr_ready}, 32'd1);
        read1(7'd7, 16'h3C3C, "inv_rd7");

        // Async reset during a pending drain with read data on the outputs.
        bus.wr_vld = 1'b1; bus.wr_index = 7'd11; bus.wr_din = 16'h5555; bus.wr_bmask = 16'hFFFF;
        bus.rd_vld = 1'b1; bus.rd_index = 7'd0;
        step();
        bus.wr_vld = 1'b0; bus.rd_vld = 1'b0;
        chk("pre_rst_vld", {31'd0, bus.rd_data_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd_vld", {31'd0, bus.rd_data_vld}, 32'd0);
        chk("arst_rd_data", {16'd0, bus.rd_data}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd1);
        chk("arst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        count_busy("arst_sweep_len");
        chk("arst_wr_ready_idle", {31'd0, bus.wr_ready}, 32'd1);
        read1(7'd11, 16'h3C3C, "arst_rd11");
        read1(7'd9, 16'h3C3C, "arst_rd9");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ct_ifu_bht_sel_array_ctrl.md
# ct_ifu_bht_sel_array_ctrl

Parametrised BHT selector array controller for the IFU: wraps a single-port SRAM (1-cycle read latency, active-low CEN/GWEN/bit-WEN) behind a gated clock. It adds what the bare array lacks: a post-reset/on-demand initialisation sweep, a one-entry write buffer that lets predictor updates yield to fetch reads, and read bypass from that buffer. It sits between BHT predict/update logic and the selector SRAM.

## Interface
- DEPTH, 128, number of entries (power of two, ≥4)
- WIDTH, 16, bits per entry
- INIT_VAL, {WIDTH{1'b0}}, value written to every entry by the sweep
- IDX_W, $clog2(DEPTH), derived index width (localparam)
- forever_cpuclk  in  1  ungated core clock
- cpurst_b  in  1  reset; asynchronous, active-low
- cp0_yy_clk_en, cp0_ifu_icg_en, pad_yy_icg_scan_en  in  1 each  ICG controls
- inv_req  in  1  pulse: restart init sweep
- busy  out  1  sweep in progress
- rd_vld  in  1  read request
- rd_index  in  IDX_W  read index
- rd_ready  out  1  = ~busy
- rd_data_vld  out  1  read data valid
- rd_data  out  WIDTH  read data, forced 0 when rd_data_vld=0
- wr_vld  in  1  update request
- wr_index  in  IDX_W  update index
- wr_din  in  WIDTH  update data
- wr_bmask  in  WIDTH  1 = write that bit
- wr_ready  out  1  = ~busy & ~buf_vld

## Operation
- FSM states: INIT, IDLE. Reset → INIT with sweep counter 0.
- INIT: each cycle write INIT_VAL (all bits) to entry cnt, cnt++; after entry DEPTH-1 → IDLE. Sweep takes exactly DEPTH cycles.
- inv_req in any state: cnt←0, state←INIT, write buffer discarded, in-flight rd_data_vld for a read issued the same cycle suppressed.
- Reads/writes handshake: accepted when vld & ready in same cycle. Requests while not ready are ignored (no queuing).
- Write buffer (1 entry: buf_vld, index, din, bmask): accepted write loads it at the next edge.
- SRAM port priority per cycle: sweep > accepted read > buffer drain. Drain = SRAM write with WEN=~bmask; buf_vld clears at that edge.
- Bypass: at read issue, if buf_vld & buf_index==rd_index, capture buf din/bmask; returned data = (sram_q & ~bmask) | (din & bmask). Otherwise sram_q.
- Ordering: reads observe every write accepted in an earlier cycle; a write accepted in the same cycle as a read to the same index is not visible to that read.
- SRAM clock local enable = INIT | read accepted | drain | inv_req.

## Timing
- Read accepted cycle T → rd_data_vld=1, rd_data valid in T+1 (single-cycle pulse per read).
- Write accepted T → buffered at T+1 → drained in first cycle ≥T+1 without a read; wr_ready low from T+1 until the cycle after drain.
- Back-to-back reads every cycle stall drain indefinitely; bypass keeps data coherent.
- Reset values: busy=1, state=INIT, cnt=0, buf_vld=0, rd_data_vld=0, rd_data=0, wr_ready=0, rd_ready=0.
- Reset asserted mid-sweep or mid-drain: all state cleared, sweep restarts from 0 after release; buffered write lost.
- cnt wraps only via FSM exit; no counter overflow beyond DEPTH-1.

## Structure
- Shared package ct_ifu_bht_pkg: FSM state enum (INIT/IDLE), default DEPTH/WIDTH constants.
- Sub-modules: gated_clk_cell for SRAM clock; ct_spsram_param (DEPTH×WIDTH, bit-write, 1-cycle read) as the array; the controller logic itself is flat.

## Test plan
- Reset release, DEPTH=128 → busy high exactly 128 cycles; then read every index returns INIT_VAL.
- Write idx 5 din=16'hA5A5 bmask=16'h00FF, next cycle read idx 5 (buffer still held) → rd_data=16'h00A5 via bypass, then after drain read → same value from SRAM.
- Write accepted, reads to other indices for 10 cycles → wr_ready stays 0, drain occurs first idle cycle, wr_ready rises next cycle.
- Same-cycle read and write idx 9 (entry 16'h0000, din 16'hFFFF, mask all) → read returns 16'h0000; following read returns 16'hFFFF.
- inv_req at sweep count 60 → count restarts, busy stays high 128 further cycles; pending buffered write discarded.
- Async reset asserted mid-drain → all outputs to reset values immediately; full sweep after release.
